block_word_reader_288: RTL and testbench
========================================

Name: block_word_reader_288

Overview:
Read-side counterpart of the 288-bit block store. It accepts a full 288-bit block through a valid/ready load handshake and streams it out as nine 32-bit words, most-significant word first, over a valid/ready word interface. It sits between the saved-block register and the SHA-256 message scheduler's word input. It provides back-pressure in both directions and a flush for aborting a block mid-stream.

Parameters:
WORD_W, 32, width of one output word in bits
NUM_WORDS, 9, words per block; block width is WORD_W*NUM_WORDS = 288
CNT_W, 4, width of the word index counter; must satisfy 2^CNT_W >= NUM_WORDS

Ports:
CLK  input  1  clock; all logic on rising edge
RST  input  1  synchronous, active-high reset
flush  input  1  synchronous abort; drops the current block, returns to IDLE
load_valid  input  1  block_in holds a block to capture
load_ready  output  1  reader can accept a block
block_in  input  288  block to serialize; bits [287:256] are word 0
word_valid  output  1  word_out is valid
word_ready  input  1  downstream accepts word_out
word_out  output  32  current word
word_idx  output  4  index of word_out, 0..8
word_last  output  1  word_out is word 8
done  output  1  one-cycle pulse after word 8 is accepted

Behaviour:
- One clock, CLK. RST is synchronous and active-high. All outputs are registered or decoded only from registered state. Outputs are never combinational from inputs.
- Reset (RST=1 at a rising edge): state=IDLE, shift register=0, count=0, done=0. Resulting outputs: load_ready=1, word_valid=0, word_out=0, word_idx=0, word_last=0.
- State IDLE:
  - load_ready=1, word_valid=0.
  - When load_valid=1, the reader captures block_in into a 288-bit shift register, sets count=0, and moves to SEND.
- State SEND:
  - load_ready=0, word_valid=1.
  - word_out = shift_reg[287:256], word_idx = count, word_last = (count == NUM_WORDS-1).
- Word handshake (word_valid && word_ready in SEND):
  - If count < 8: shift register shifts left by 32 with zero fill, and count increments.
  - If count == 8: state goes to IDLE, count goes to 0, shift register is cleared, done=1 for the next cycle only.
- Stall (word_ready=0): word_out, word_idx and word_last hold stable. word_valid stays 1 until the handshake completes.
- Latency:
  - Load accepted at edge N: word 0 is valid from edge N+1 onward.
  - With word_ready held at 1, words 0..8 appear on 9 consecutive cycles.
  - done is high in the cycle after the word-8 handshake, and load_ready returns to 1 in that same cycle.
  - Minimum block period is 10 cycles; there is no overlap of load and send.
- load_valid while in SEND is ignored; load_ready=0 and block_in is not sampled.
- flush=1 at an edge, in any state: state goes to IDLE, count goes to 0, shift register is cleared, done=0.
  - flush beats a simultaneous load (no capture) and a simultaneous word handshake (done is not pulsed).
- RST beats flush and every other event. Reset mid-block behaves as flush and additionally forces done=0.
- word_idx never exceeds 8. The counter does not wrap past NUM_WORDS-1.

Test Plan:
- Reset then idle: hold RST=1 for 2 cycles, then release -> load_ready=1, word_valid=0, word_out=0, done=0.
- Full-rate stream: load block_in = {32'h00000000, 32'h11111111, ..., 32'h88888888} with word_ready=1 -> words 0..8 on 9 consecutive cycles with those values, word_idx 0..8, word_last only on 32'h88888888, done pulses once, load_ready=1 in the done cycle.
- Back-pressure: same block, word_ready toggling 1,0,0,1,... -> each word is held stable while word_ready=0, no word is skipped or duplicated, and the total sequence matches exactly.
- Load ignored while busy: during SEND, assert load_valid with block_in all 32'hDEADBEEF -> the output stream is unchanged, and the new block is accepted only after done.
- Flush mid-block: flush=1 while word_idx=4 is stalled -> next cycle state is IDLE, word_valid=0, load_ready=1, no done pulse. A new block then starts at word_idx=0.
- Simultaneous events: flush=1 with the word-8 handshake -> no done pulse. flush=1 with load_valid=1 in IDLE -> no capture, word_valid stays 0.

Source files
------------

// File: rtl/block_word_reader_288.sv
// Serializes a 288-bit block into nine 32-bit words, most-significant word first,
// with valid/ready handshakes on both the block load and the word stream.
module block_word_reader_288 #(
   parameter int unsigned WORD_W    = 32,
   parameter int unsigned NUM_WORDS = 9,
   parameter int unsigned CNT_W     = 4
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        flush,
   input  logic                        load_valid,
   output logic                        load_ready,
   input  logic [WORD_W*NUM_WORDS-1:0] block_in,
   output logic                        word_valid,
   input  logic                        word_ready,
   output logic [WORD_W-1:0]           word_out,
   output logic [CNT_W-1:0]            word_idx,
   output logic                        word_last,
   output logic                        done
);

   localparam int unsigned      BLK_W    = WORD_W * NUM_WORDS;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

   typedef enum logic {
      S_IDLE,
      S_SEND
   } state_t;

   state_t           state_q, state_d;
   logic [BLK_W-1:0] shift_q, shift_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // flush overrides both a pending load and the final word handshake
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      if (flush) begin
         state_d = S_IDLE;
         shift_d = '0;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (load_valid) begin
                  shift_d = block_in;
                  cnt_d   = '0;
                  state_d = S_SEND;
               end
            end
            S_SEND: begin
               if (word_ready) begin
                  if (cnt_q == LAST_IDX) begin
                     state_d = S_IDLE;
                     shift_d = '0;
                     cnt_d   = '0;
                     done_d  = 1'b1;
                  end else begin
                     shift_d = {shift_q[BLK_W-WORD_W-1:0], {WORD_W{1'b0}}};
                     cnt_d   = cnt_q + CNT_W'(1);
                  end
               end
            end
         endcase
      end
   end

   always_comb begin
      load_ready = (state_q == S_IDLE);
      word_valid = (state_q == S_SEND);
      word_out   = shift_q[BLK_W-1 -: WORD_W];
      word_idx   = cnt_q;
      word_last  = (state_q == S_SEND) && (cnt_q == LAST_IDX);
      done       = done_q;
   end

endmodule

// File: tb/tb_block_word_reader_288.sv
// Directed bench for block_word_reader_288: table-driven vectors plus a
// hand-written back-pressure sequence with a small word-index tracker.
module tb_block_word_reader_288;

   logic         CLK = 1'b0;
   logic         RST = 1'b0;
   logic         flush = 1'b0;
   logic         load_valid = 1'b0;
   logic         load_ready;
   logic [287:0] block_in = '0;
   logic         word_valid;
   logic         word_ready = 1'b0;
   logic [31:0]  word_out;
   logic [3:0]   word_idx;
   logic         word_last;
   logic         done;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   block_word_reader_288 #(.WORD_W(32), .NUM_WORDS(9), .CNT_W(4)) dut (
      .CLK(CLK), .RST(RST), .flush(flush),
      .load_valid(load_valid), .load_ready(load_ready), .block_in(block_in),
      .word_valid(word_valid), .word_ready(word_ready), .word_out(word_out),
      .word_idx(word_idx), .word_last(word_last), .done(done)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        rst, fl, lv, wr;
      int          blk;        // 0: zeros, 1: block A, 2: all DEADBEEF
      logic        e_lr, e_wv;
      logic [31:0] e_wo;
      logic [3:0]  e_idx;
      logic        e_last, e_done;
   } vec_t;

   vec_t vecs[$];

   localparam int BZ = 0, BA = 1, BD = 2;

   function automatic logic [31:0] w(int i);
      return 32'h11111111 * i;
   endfunction

   function automatic logic [287:0] blk_val(int sel);
      logic [287:0] b;
      b = '0;
      if (sel == BA) for (int i = 0; i < 9; i++) b[287 - 32*i -: 32] = w(i);
      if (sel == BD) for (int i = 0; i < 9; i++) b[287 - 32*i -: 32] = 32'hDEADBEEF;
      return b;
   endfunction

   task automatic add(input logic rst, fl, lv, wr, input int blk,
                      input logic lr, wv, input logic [31:0] wo,
                      input int idx, input logic last, dn);
      vec_t v;
      v.rst = rst; v.fl = fl; v.lv = lv; v.wr = wr; v.blk = blk;
      v.e_lr = lr; v.e_wv = wv; v.e_wo = wo; v.e_idx = 4'(idx);
      v.e_last = last; v.e_done = dn;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic lr, wv, input logic [31:0] wo,
                           input logic [3:0] idx, input logic last, dn);
      chk({tag, ".load_ready"}, 64'(load_ready), 64'(lr));
      chk({tag, ".word_valid"}, 64'(word_valid), 64'(wv));
      chk({tag, ".word_out"},   64'(word_out),   64'(wo));
      chk({tag, ".word_idx"},   64'(word_idx),   64'(idx));
      chk({tag, ".word_last"},  64'(word_last),  64'(last));
      chk({tag, ".done"},       64'(done),       64'(dn));
   endtask

   initial begin
      int  exp_i;
      bit  finished;

      // reset, then idle
      add(1,0,0,0,BZ, 1,0,0,0,0,0);
      add(1,0,0,0,BZ, 1,0,0,0,0,0);
      add(0,0,0,0,BZ, 1,0,0,0,0,0);
      // full-rate stream
      add(0,0,1,1,BA, 0,1,w(0),0,0,0);
      for (int i = 1; i <= 8; i++) add(0,0,0,1,BZ, 0,1,w(i),i,(i == 8),0);
      add(0,0,0,1,BZ, 1,0,0,0,0,1);
      add(0,0,0,1,BZ, 1,0,0,0,0,0);
      // load ignored while busy; new block taken only after done
      add(0,0,1,1,BA, 0,1,w(0),0,0,0);
      for (int i = 1; i <= 8; i++) add(0,0,1,1,BD, 0,1,w(i),i,(i == 8),0);
      add(0,0,1,1,BD, 1,0,0,0,0,1);
      add(0,0,1,0,BD, 0,1,32'hDEADBEEF,0,0,0);
      add(0,1,0,0,BZ, 1,0,0,0,0,0);
      // flush while stalled at word 4
      add(0,0,1,1,BA, 0,1,w(0),0,0,0);
      for (int i = 1; i <= 4; i++) add(0,0,0,1,BZ, 0,1,w(i),i,0,0);
      add(0,0,0,0,BZ, 0,1,w(4),4,0,0);
      add(0,1,0,0,BZ, 1,0,0,0,0,0);
      add(0,0,0,0,BZ, 1,0,0,0,0,0);
      add(0,0,1,1,BA, 0,1,w(0),0,0,0);
      // flush together with the word-8 handshake: no done
      for (int i = 1; i <= 8; i++) add(0,0,0,1,BZ, 0,1,w(i),i,(i == 8),0);
      add(0,1,0,1,BZ, 1,0,0,0,0,0);
      add(0,0,0,0,BZ, 1,0,0,0,0,0);
      // flush together with a load in IDLE: no capture
      add(0,1,1,1,BA, 1,0,0,0,0,0);
      add(0,0,0,1,BZ, 1,0,0,0,0,0);
      // reset mid-block, including on a handshake cycle
      add(0,0,1,1,BA, 0,1,w(0),0,0,0);
      add(0,0,0,1,BZ, 0,1,w(1),1,0,0);
      add(1,0,0,1,BZ, 1,0,0,0,0,0);
      add(0,0,0,1,BZ, 1,0,0,0,0,0);

      for (int k = 0; k < vecs.size(); k++) begin
         RST        = vecs[k].rst;
         flush      = vecs[k].fl;
         load_valid = vecs[k].lv;
         word_ready = vecs[k].wr;
         block_in   = blk_val(vecs[k].blk);
         @(posedge CLK); #1;
         chk_outs($sformatf("vec%0d", k), vecs[k].e_lr, vecs[k].e_wv, vecs[k].e_wo,
                  vecs[k].e_idx, vecs[k].e_last, vecs[k].e_done);
      end

      // back-pressure: word_ready pattern 1,0,0 repeating
      RST = 0; flush = 0;
      load_valid = 1; word_ready = 0; block_in = blk_val(BA);
      @(posedge CLK); #1;
      chk_outs("bp_load", 0, 1, w(0), 0, 0, 0);
      load_valid = 0; block_in = '0;
      exp_i = 0; finished = 0;
      for (int c = 0; c < 40 && !finished; c++) begin
         word_ready = (c % 3 == 0);
         @(posedge CLK); #1;
         if (word_ready) begin
            if (exp_i == 8) finished = 1;
            else exp_i++;
         end
         if (finished) chk_outs($sformatf("bp%0d", c), 1, 0, 0, 0, 0, 1);
         else chk_outs($sformatf("bp%0d", c), 0, 1, w(exp_i), 4'(exp_i), (exp_i == 8), 0);
      end
      chk("bp_completed", 64'(finished), 64'd1);
      word_ready = 0;
      @(posedge CLK); #1;
      chk_outs("bp_after", 1, 0, 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
